pattern_buffer: RTL and testbench
=================================

PATTERN_BUFFER -- requirements
Module: pattern_buffer

Interface
REQ-001 Parameter bufp_width, 3, buffer select width; there are 2**bufp_width buffers.
REQ-002 Parameter fieldp_width, 5, field select width; each buffer holds 2**fieldp_width fields.
REQ-003 Parameter buffer_width, 8, field data width in bits.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 bufp  input  bufp_width  core buffer select, used for both read and write.
REQ-007 fieldp  input  fieldp_width  core read field address.
REQ-008 fieldwp  input  fieldp_width  core write field address.
REQ-009 write_en  input  1  core write strobe.
REQ-010 field_out  input  buffer_width  core write data.
REQ-011 field_in  output  buffer_width  core read data.
REQ-012 flush_req  input  1  request to stream one buffer out.
REQ-013 flush_buf  input  bufp_width  buffer to stream.
REQ-014 flush_ack  output  1  one-cycle pulse: flush request accepted.
REQ-015 busy  output  1  stream in progress.
REQ-016 out_valid  output  1  out_data holds a valid field.
REQ-017 out_ready  input  1  downstream accepts the field.
REQ-018 out_data  output  buffer_width  streamed field value.
REQ-019 out_last  output  1  current field is the final field of the buffer.
REQ-020 out_buf  output  bufp_width  index of the buffer being streamed.

Function
REQ-021 field_in SHALL be a combinational read of mem[bufp][fieldp].
REQ-022 When write_en=1, mem[bufp][fieldwp] SHALL take field_out at posedge.
REQ-023 FSM states SHALL be IDLE and STREAM; busy=1 exactly in STREAM.
REQ-024 In IDLE with flush_req=1: pulse flush_ack, latch flush_buf into out_buf, set index=0, register mem[flush_buf][0] into out_data, enter STREAM; out_valid=1 the next cycle.
REQ-025 flush_req in STREAM SHALL be ignored: no flush_ack, no state change.
REQ-026 A handshake SHALL be out_valid=1 and out_ready=1 at posedge.
REQ-027 While out_valid=1 and out_ready=0, out_data, out_last and out_buf SHALL hold stable.
REQ-028 On a handshake with index<max, index SHALL increment and out_data SHALL load mem[out_buf][index+1] in the same posedge.
REQ-029 out_last SHALL be 1 when index = 2**fieldp_width-1.
REQ-030 A handshake with out_last=1 SHALL return to IDLE with out_valid=0 the next cycle; a new flush is accepted no earlier than that IDLE cycle.
REQ-031 With out_ready held at 1, all fields SHALL stream at one per cycle: 32 consecutive valid cycles at default sizes.
REQ-032 A stream read in the same cycle as a core write to the same address SHALL return the old value (read-before-write).
REQ-033 Core writes to the streamed buffer SHALL always proceed; fields not yet loaded into out_data reflect the write.
REQ-034 The index SHALL be fieldp_width wide and SHALL never wrap within a stream.

Reset
REQ-035 With reset=0 at posedge: state=IDLE, index=0, out_valid=0, out_last=0, out_data=0, out_buf=0, flush_ack=0, busy=0, and all memory fields=0.
REQ-036 A reset during STREAM SHALL abort the stream; out_valid=0 from the next cycle and no further fields are emitted.

Configuration
REQ-037 Macro PATTERN_BUFFER_CLEAR_EN: when defined, each field SHALL be written to 0 on its handshake. A core write to the same address in the same cycle takes priority over the clear.
REQ-038 Without PATTERN_BUFFER_CLEAR_EN, streaming SHALL leave memory unchanged.

Verification
REQ-039 Reset, then write field k of buffer 2 = k+0x10 for k=0..31, flush buf 2 with out_ready=1 -> flush_ack one cycle, then out_data 0x10..0x2F over 32 consecutive cycles, out_last only on 0x2F, out_buf=2, busy falls after the last handshake.
REQ-040 Same stream with out_ready toggling 1,0,1,0 -> each field is held while out_ready=0, no field is lost or duplicated, and the stream takes 64 cycles.
REQ-041 flush_req buf 5 issued mid-stream of buf 2 -> no flush_ack and out_buf stays 2; the same request issued after busy falls -> accepted.
REQ-042 During a stream at index 3, core writes 0xAA to field 10 and 0xBB to field 3 of the streamed buffer -> field 10 emits 0xAA and field 3 emits its old value.
REQ-043 reset=0 asserted at index 7 -> out_valid=0 next cycle, and field_in reads 0 at every address.
REQ-044 With PATTERN_BUFFER_CLEAR_EN defined, stream buf 1 and then read it via fieldp -> all fields read 0. Without the macro -> the original data remains.

Source files
------------

// File: rtl/pattern_buffer.sv
// -----------------------------------------------------------------------------
// pattern_buffer
//
// A bank of 2**bufp_width buffers, each holding 2**fieldp_width fields of
// buffer_width bits. The core side has one combinational read port and one
// synchronous write port. A flush request streams one whole buffer out over a
// valid/ready interface, one field per accepted handshake.
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   reset      synchronous, active-low reset (clears state and all fields)
//   bufp       core buffer select (shared by read and write)
//   fieldp     core read field address
//   fieldwp    core write field address
//   write_en   core write strobe
//   field_out  core write data
//   field_in   core read data (combinational)
//   flush_req  request to stream the buffer named by flush_buf
//   flush_buf  buffer to stream
//   flush_ack  one-cycle pulse, high in the first cycle after acceptance
//   busy       a stream is in progress
//   out_valid  out_data holds a valid field
//   out_ready  downstream accepts the field
//   out_data   streamed field value
//   out_last   current field is the final field of the buffer
//   out_buf    index of the buffer being streamed
//
// Configuration macro:
//   PATTERN_BUFFER_CLEAR_EN  when defined, each streamed field is written to
//                            zero on its handshake; a core write to the same
//                            address in the same cycle wins over the clear.
// -----------------------------------------------------------------------------
module pattern_buffer #(
    parameter int bufp_width   = 3,
    parameter int fieldp_width = 5,
    parameter int buffer_width = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [bufp_width-1:0]   bufp,
    input  logic [fieldp_width-1:0] fieldp,
    input  logic [fieldp_width-1:0] fieldwp,
    input  logic                    write_en,
    input  logic [buffer_width-1:0] field_out,
    output logic [buffer_width-1:0] field_in,
    input  logic                    flush_req,
    input  logic [bufp_width-1:0]   flush_buf,
    output logic                    flush_ack,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [buffer_width-1:0] out_data,
    output logic                    out_last,
    output logic [bufp_width-1:0]   out_buf
);

    localparam int NUM_BUF   = 2 ** bufp_width;
    localparam int NUM_FIELD = 2 ** fieldp_width;

    localparam logic [fieldp_width-1:0] IDX_MAX    = {fieldp_width{1'b1}};
    localparam logic [fieldp_width-1:0] IDX_ZERO   = {fieldp_width{1'b0}};
    localparam logic [fieldp_width-1:0] IDX_ONE    = {{(fieldp_width-1){1'b0}}, 1'b1};
    localparam logic [buffer_width-1:0] DATA_ZERO  = {buffer_width{1'b0}};
    localparam logic [bufp_width-1:0]   BUF_ZERO   = {bufp_width{1'b0}};

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Field storage, indexed [buffer][field].
    logic [buffer_width-1:0] mem_r [0:NUM_BUF-1][0:NUM_FIELD-1];

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [fieldp_width-1:0] index_r;
    logic [fieldp_width-1:0] index_nxt_s;
    logic [fieldp_width-1:0] index_inc_s;
    logic [buffer_width-1:0] out_data_r;
    logic [buffer_width-1:0] out_data_nxt_s;
    logic                    out_last_r;
    logic                    out_last_nxt_s;
    logic [bufp_width-1:0]   out_buf_r;
    logic [bufp_width-1:0]   out_buf_nxt_s;
    logic                    out_valid_r;
    logic                    out_valid_nxt_s;
    logic                    flush_ack_r;
    logic                    flush_ack_nxt_s;
    logic                    busy_r;
    logic                    busy_nxt_s;
    logic                    handshake_s;

    // out_valid is only ever high in STREAM, so a handshake implies STREAM.
    assign handshake_s = out_valid_r & out_ready;
    assign index_inc_s = index_r + IDX_ONE;

    // Core read port is a plain combinational lookup.
    assign field_in = mem_r[bufp][fieldp];

    assign flush_ack = flush_ack_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign out_buf   = out_buf_r;

`ifdef PATTERN_BUFFER_CLEAR_EN
    logic clear_s;
    // A field is consumed exactly when it is handshaken.
    assign clear_s = handshake_s;
`endif

    // Field storage: reset clears every field; core write has the last word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BUF; b++) begin
                for (int f = 0; f < NUM_FIELD; f++) begin
                    mem_r[b][f] <= DATA_ZERO;
                end
            end
        end else begin
`ifdef PATTERN_BUFFER_CLEAR_EN
            if (clear_s) begin
                mem_r[out_buf_r][index_r] <= DATA_ZERO;
            end
`endif
            // Written after the clear so a same-address core write wins.
            if (write_en) begin
                mem_r[bufp][fieldwp] <= field_out;
            end
        end
    end

    // Next-state and next-output logic for the flush streamer.
    always_comb begin
        state_nxt_s     = state_r;
        index_nxt_s     = index_r;
        out_data_nxt_s  = out_data_r;
        out_last_nxt_s  = out_last_r;
        out_buf_nxt_s   = out_buf_r;
        out_valid_nxt_s = out_valid_r;
        flush_ack_nxt_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (flush_req) begin
                    // Prefetch field 0 so out_valid can rise on the next cycle.
                    state_nxt_s     = STREAM;
                    index_nxt_s     = IDX_ZERO;
                    out_buf_nxt_s   = flush_buf;
                    out_data_nxt_s  = mem_r[flush_buf][IDX_ZERO];
                    out_last_nxt_s  = (IDX_ZERO == IDX_MAX);
                    out_valid_nxt_s = 1'b1;
                    flush_ack_nxt_s = 1'b1;
                end else begin
                    out_valid_nxt_s = 1'b0;
                    out_last_nxt_s  = 1'b0;
                end
            end
            STREAM: begin
                // flush_req is deliberately not looked at here.
                if (handshake_s) begin
                    if (index_r == IDX_MAX) begin
                        state_nxt_s     = IDLE;
                        index_nxt_s     = IDX_ZERO;
                        out_valid_nxt_s = 1'b0;
                        out_last_nxt_s  = 1'b0;
                    end else begin
                        // The memory read sees pre-edge contents, so a core
                        // write landing on this same field this cycle is not
                        // visible until the next stream.
                        index_nxt_s    = index_inc_s;
                        out_data_nxt_s = mem_r[out_buf_r][index_inc_s];
                        out_last_nxt_s = (index_inc_s == IDX_MAX);
                    end
                end else begin
                    // Downstream stalled: hold everything.
                    index_nxt_s = index_r;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                index_nxt_s     = IDX_ZERO;
                out_valid_nxt_s = 1'b0;
                out_last_nxt_s  = 1'b0;
            end
        endcase

        busy_nxt_s = (state_nxt_s == STREAM);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            index_r     <= IDX_ZERO;
            out_data_r  <= DATA_ZERO;
            out_last_r  <= 1'b0;
            out_buf_r   <= BUF_ZERO;
            out_valid_r <= 1'b0;
            flush_ack_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            index_r     <= index_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_last_r  <= out_last_nxt_s;
            out_buf_r   <= out_buf_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            flush_ack_r <= flush_ack_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_pattern_buffer.sv
// -----------------------------------------------------------------------------
// tb_pattern_buffer
//
// Directed bench for pattern_buffer. A field-level reference model (memory
// image plus "which buffer, which position, what value is presented") is
// compared against the DUT on every cycle; directed scenarios add literal
// expectations for the streamed sequences.
// -----------------------------------------------------------------------------
module tb_pattern_buffer;

    localparam int BW = 3;
    localparam int FW = 5;
    localparam int DW = 8;
    localparam int NB = 8;
    localparam int NF = 32;

    logic          clk;
    logic          reset;
    logic [BW-1:0] bufp;
    logic [FW-1:0] fieldp;
    logic [FW-1:0] fieldwp;
    logic          write_en;
    logic [DW-1:0] field_out;
    logic [DW-1:0] field_in;
    logic          flush_req;
    logic [BW-1:0] flush_buf;
    logic          flush_ack;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [BW-1:0] out_buf;

    pattern_buffer #(
        .bufp_width  (BW),
        .fieldp_width(FW),
        .buffer_width(DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bufp     (bufp),
        .fieldp   (fieldp),
        .fieldwp  (fieldwp),
        .write_en (write_en),
        .field_out(field_out),
        .field_in (field_in),
        .flush_req(flush_req),
        .flush_buf(flush_buf),
        .flush_ack(flush_ack),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .out_buf  (out_buf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [NB][NF];
    logic          m_busy;
    logic          m_ack;
    logic [BW-1:0] m_buf;
    int            m_pos;
    logic [DW-1:0] m_data;

    // Field-level model: memory image plus the field currently presented.
    always @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < NB; b++)
                for (int f = 0; f < NF; f++)
                    m_mem[b][f] <= 8'h00;
            m_busy <= 1'b0;
            m_ack  <= 1'b0;
            m_buf  <= 3'd0;
            m_pos  <= 0;
            m_data <= 8'h00;
        end else begin
            m_ack <= 1'b0;
            if (!m_busy) begin
                if (flush_req) begin
                    m_busy <= 1'b1;
                    m_ack  <= 1'b1;
                    m_buf  <= flush_buf;
                    m_pos  <= 0;
                    m_data <= m_mem[flush_buf][0];
                end
            end else if (out_ready) begin
`ifdef PATTERN_BUFFER_CLEAR_EN
                m_mem[m_buf][m_pos] <= 8'h00;
`endif
                if (m_pos == NF - 1) begin
                    m_busy <= 1'b0;
                end else begin
                    m_pos  <= m_pos + 1;
                    m_data <= m_mem[m_buf][m_pos + 1];
                end
            end
            if (write_en) m_mem[bufp][fieldwp] <= field_out;
        end
    end

    // ---------------- bookkeeping ----------------
    int            checks;
    int            errors;
    logic          chk_en;
    int            vcnt;
    int            acnt;
    logic [DW-1:0] dq [$];
    logic          lq [$];
    logic [BW-1:0] bq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model plus handshake recording.
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_out_valid", 32'(out_valid), 32'(m_busy));
                check("cyc_busy", 32'(busy), 32'(m_busy));
                check("cyc_flush_ack", 32'(flush_ack), 32'(m_ack));
                check("cyc_field_in", 32'(field_in), 32'(m_mem[bufp][fieldp]));
                if (m_busy) begin
                    check("cyc_out_data", 32'(out_data), 32'(m_data));
                    check("cyc_out_last", 32'(out_last), 32'(m_pos == NF - 1));
                    check("cyc_out_buf", 32'(out_buf), 32'(m_buf));
                end
                if (out_valid) vcnt++;
                if (flush_ack) acnt++;
                if (out_valid && out_ready) begin
                    dq.push_back(out_data);
                    lq.push_back(out_last);
                    bq.push_back(out_buf);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_buf(input logic [BW-1:0] b, input logic [DW-1:0] base);
        for (int k = 0; k < NF; k++) begin
            bufp      = b;
            fieldwp   = FW'(k);
            field_out = base + DW'(k);
            write_en  = 1'b1;
            step();
        end
        write_en = 1'b0;
    endtask

    task automatic flush(input logic [BW-1:0] b);
        flush_req = 1'b1;
        flush_buf = b;
        step();
        flush_req = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy === 1'b1 && t < 200) begin
            step();
            t++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_hs(input int n, input int base);
        int t = 0;
        while ((dq.size() - base) < n && t < 100) begin
            step();
            t++;
        end
        check("hs_timeout", 32'(dq.size() - base), 32'(n));
    endtask

    // Check a whole recorded stream of buffer b whose fields were base+k.
    task automatic check_stream(input string tag, input int qb, input logic [BW-1:0] b,
                                input logic [DW-1:0] base);
        int bad_last = 0;
        int bad_buf  = 0;
        check({tag, "_count"}, 32'(dq.size() - qb), 32'd32);
        if (dq.size() - qb >= NF) begin
            for (int k = 0; k < NF; k++) begin
                logic [DW-1:0] e;
                e = base + DW'(k);
                check($sformatf("%s_data%0d", tag, k), 32'(dq[qb + k]), 32'(e));
                if (lq[qb + k] !== (k == NF - 1)) bad_last++;
                if (bq[qb + k] !== b) bad_buf++;
            end
        end
        check({tag, "_last_placement"}, 32'(bad_last), 32'd0);
        check({tag, "_buf_stable"}, 32'(bad_buf), 32'd0);
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int qb;
        int vb;
        int ab;
        int t;
        int bad;

        checks    = 0;
        errors    = 0;
        chk_en    = 1'b0;
        vcnt      = 0;
        acnt      = 0;
        reset     = 1'b0;
        bufp      = 3'd0;
        fieldp    = 5'd0;
        fieldwp   = 5'd0;
        write_en  = 1'b0;
        field_out = 8'h00;
        flush_req = 1'b1;
        flush_buf = 3'd4;
        out_ready = 1'b1;

        fork
            compare_loop();
        join_none

        // Reset held with a flush request present: nothing may start.
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flush_ack", 32'(flush_ack), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_buf", 32'(out_buf), 32'd0);
        check("rst_field_in", 32'(field_in), 32'd0);
        flush_req = 1'b0;
        chk_en    = 1'b1;
        reset     = 1'b1;
        step();

        // Full-rate stream of buffer 2.
        fill_buf(3'd2, 8'h10);
        out_ready = 1'b1;
        qb = dq.size();
        vb = vcnt;
        ab = acnt;
        flush(3'd2);
        check("t1_ack_pulse", 32'(flush_ack), 32'd1);
        check("t1_first_data", 32'(out_data), 32'h10);
        check("t1_out_buf", 32'(out_buf), 32'd2);
        step();
        check("t1_ack_drop", 32'(flush_ack), 32'd0);
        wait_idle();
        check_stream("t1", qb, 3'd2, 8'h10);
        check("t1_valid_cycles", 32'(vcnt - vb), 32'd32);
        check("t1_ack_cycles", 32'(acnt - ab), 32'd1);

        // Toggling ready, with a competing flush request raised mid-stream.
        fill_buf(3'd2, 8'h10);
        out_ready = 1'b1;
        qb = dq.size();
        vb = vcnt;
        ab = acnt;
        flush(3'd2);
        t = 0;
        while (busy === 1'b1 && t < 200) begin
            out_ready = ~out_ready;
            if (t == 9) begin
                flush_req = 1'b1;
                flush_buf = 3'd5;
            end
            step();
            t++;
        end
        check_stream("t2", qb, 3'd2, 8'h10);
        check("t2_valid_cycles", 32'(vcnt - vb), 32'd64);
        check("t2_ack_cycles", 32'(acnt - ab), 32'd1);
        check("t2_idle_no_ack", 32'(flush_ack), 32'd0);
        out_ready = 1'b1;
        step();
        flush_req = 1'b0;
        check("t3_ack_after_idle", 32'(flush_ack), 32'd1);
        check("t3_out_buf", 32'(out_buf), 32'd5);
        check("t3_busy", 32'(busy), 32'd1);
        wait_idle();

        // Core writes into the buffer being streamed.
        fill_buf(3'd2, 8'h10);
        out_ready = 1'b1;
        qb = dq.size();
        flush(3'd2);
        wait_hs(3, qb);
        check("t4_at_index3", 32'(out_data), 32'h13);
        out_ready = 1'b0;
        bufp      = 3'd2;
        write_en  = 1'b1;
        fieldwp   = 5'd10;
        field_out = 8'hAA;
        step();
        fieldwp   = 5'd3;
        field_out = 8'hBB;
        step();
        fieldwp   = 5'd4;
        field_out = 8'hCC;
        out_ready = 1'b1;
        step();
        write_en  = 1'b0;
        wait_idle();
        check("t4_count", 32'(dq.size() - qb), 32'd32);
        if (dq.size() - qb >= NF) begin
            check("t4_field3_old", 32'(dq[qb + 3]), 32'h13);
            check("t4_field4_rbw", 32'(dq[qb + 4]), 32'h14);
            check("t4_field10_new", 32'(dq[qb + 10]), 32'hAA);
            check("t4_field11", 32'(dq[qb + 11]), 32'h1B);
        end

        // Buffer contents after a stream (cleared only with the clear option).
        fill_buf(3'd1, 8'h40);
        out_ready = 1'b1;
        flush(3'd1);
        wait_idle();
        for (int k = 0; k < NF; k++) begin
            logic [DW-1:0] e;
`ifdef PATTERN_BUFFER_CLEAR_EN
            e = 8'h00;
`else
            e = 8'h40 + DW'(k);
`endif
            bufp   = 3'd1;
            fieldp = FW'(k);
            #1;
            check($sformatf("t5_readback%0d", k), 32'(field_in), 32'(e));
        end

        // Reset in the middle of a stream.
        fill_buf(3'd2, 8'h10);
        out_ready = 1'b1;
        qb = dq.size();
        flush(3'd2);
        wait_hs(7, qb);
        check("t6_at_index7", 32'(out_data), 32'h17);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("t6_valid_drop", 32'(out_valid), 32'd0);
        check("t6_busy_drop", 32'(busy), 32'd0);
        check("t6_out_data", 32'(out_data), 32'd0);
        check("t6_out_last", 32'(out_last), 32'd0);
        check("t6_out_buf", 32'(out_buf), 32'd0);
        vb = vcnt;
        step();
        step();
        step();
        check("t6_no_more_fields", 32'(vcnt - vb), 32'd0);
        bad = 0;
        for (int b = 0; b < NB; b++) begin
            for (int f = 0; f < NF; f++) begin
                bufp   = BW'(b);
                fieldp = FW'(f);
                #1;
                if (field_in !== 8'h00) bad++;
            end
        end
        check("t6_mem_cleared", 32'(bad), 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
